// File: rtl/fmap_window_buf.sv
// Feature-map frame buffer: raster writes fill ROWS x COLS pixels, then K x K windows
// are scanned at STRIDE over a valid/ready port. Optional FMAP_WIN_MAX_EN adds win_max.
module fmap_window_buf #(
  parameter int DW     = 18,
  parameter int ROWS   = 11,
  parameter int COLS   = 11,
  parameter int K      = 2,
  parameter int STRIDE = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic [DW-1:0]             wr_data,
  output logic                      win_valid,
  input  logic                      win_ready,
  output logic [K*K*DW-1:0]         win_data,
  output logic [$clog2(ROWS)-1:0]   win_row,
  output logic [$clog2(COLS)-1:0]   win_col,
  output logic                      win_last
`ifdef FMAP_WIN_MAX_EN
  ,
  output logic signed [DW-1:0]      win_max
`endif
);

  localparam int NPIX = ROWS * COLS;
  localparam int AW   = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int STEP = (STRIDE > 0) ? STRIDE : 1;
  localparam int NWR  = (ROWS - K) / STEP + 1;
  localparam int NWC  = (COLS - K) / STEP + 1;
  localparam int RIW  = (NWR > 1) ? $clog2(NWR) : 1;
  localparam int CIW  = (NWC > 1) ? $clog2(NWC) : 1;
  localparam int RW   = $clog2(ROWS);
  localparam int CW   = $clog2(COLS);

  if (K < 1 || STRIDE < 1 || K > ROWS || K > COLS) begin : g_bad_cfg
    $error("fmap_window_buf: need 1 <= K <= ROWS, K <= COLS and STRIDE >= 1");
  end

  typedef enum logic [1:0] {FILL, SCAN, DRAIN} state_t;

  state_t               r_state, w_state_nxt;
  logic [DW-1:0]        r_mem [NPIX];
  logic [AW-1:0]        r_ptr;
  logic [RIW-1:0]       r_ri;
  logic [CIW-1:0]       r_ci;
  logic                 r_win_valid;
  logic                 r_win_last;
  logic [K*K*DW-1:0]    r_win_data;
  logic [RW-1:0]        r_win_row;
  logic [CW-1:0]        r_win_col;

  logic                 w_wr_fire;
  logic                 w_load;
  logic                 w_drain_done;
  logic                 w_ptr_end;
  logic                 w_col_end;
  logic                 w_at_last;
  int                   w_base;
  logic [K*K*DW-1:0]    w_gather;

  function automatic logic signed [DW-1:0] smax(input logic signed [DW-1:0] a,
                                                input logic signed [DW-1:0] b);
    return (a > b) ? a : b;
  endfunction

  assign w_ptr_end = (r_ptr == AW'(NPIX - 1));
  assign w_col_end = (r_ci == CIW'(NWC - 1));
  assign w_at_last = w_col_end && (r_ri == RIW'(NWR - 1));

  always_comb begin
    w_state_nxt  = r_state;
    w_wr_fire    = 1'b0;
    w_load       = 1'b0;
    w_drain_done = 1'b0;
    case (r_state)
      FILL: begin
        w_wr_fire = wr_valid;
        if (wr_valid && w_ptr_end) w_state_nxt = SCAN;
      end
      SCAN: begin
        w_load = !r_win_valid || win_ready;
        if (w_load && w_at_last) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        // Only the final window is outstanding here, so its handshake ends the frame.
        w_drain_done = r_win_valid && win_ready;
        if (w_drain_done) w_state_nxt = FILL;
      end
      default: w_state_nxt = FILL;
    endcase
  end

  always_comb begin
    w_base   = int'(r_ri) * STEP * COLS + int'(r_ci) * STEP;
    w_gather = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        w_gather[(r*K+c)*DW +: DW] = r_mem[AW'(w_base + r*COLS + c)];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)      r_state <= FILL;
    else if (flush)  r_state <= FILL;
    else             r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst_n && !flush && w_wr_fire) r_mem[r_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr       <= '0;
      r_ri        <= '0;
      r_ci        <= '0;
      r_win_valid <= 1'b0;
      r_win_last  <= 1'b0;
      r_win_data  <= '0;
      r_win_row   <= '0;
      r_win_col   <= '0;
    end else if (flush) begin
      r_ptr       <= '0;
      r_ri        <= '0;
      r_ci        <= '0;
      r_win_valid <= 1'b0;
      r_win_last  <= 1'b0;
    end else begin
      if (w_wr_fire) r_ptr <= w_ptr_end ? '0 : r_ptr + AW'(1);
      if (w_load) begin
        r_win_valid <= 1'b1;
        r_win_last  <= w_at_last;
        r_win_data  <= w_gather;
        r_win_row   <= RW'(int'(r_ri) * STEP);
        r_win_col   <= CW'(int'(r_ci) * STEP);
        if (w_col_end) begin
          r_ci <= '0;
          r_ri <= w_at_last ? '0 : r_ri + RIW'(1);
        end else begin
          r_ci <= r_ci + CIW'(1);
        end
      end
      if (w_drain_done) begin
        r_win_valid <= 1'b0;
        r_win_last  <= 1'b0;
      end
    end
  end

`ifdef FMAP_WIN_MAX_EN
  logic signed [DW-1:0] w_max;
  logic signed [DW-1:0] r_win_max;

  always_comb begin
    w_max = signed'(w_gather[DW-1:0]);
    for (int e = 1; e < K*K; e++) begin
      w_max = smax(w_max, signed'(w_gather[e*DW +: DW]));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)                r_win_max <= '0;
    else if (!flush && w_load) r_win_max <= w_max;
  end

  assign win_max = r_win_max;
`endif

  assign wr_ready  = (r_state == FILL);
  assign win_valid = r_win_valid;
  assign win_last  = r_win_last;
  assign win_data  = r_win_data;
  assign win_row   = r_win_row;
  assign win_col   = r_win_col;

endmodule

// File: tb/tb_fmap_window_buf.sv
// Scoreboard bench for fmap_window_buf: three instances (4x4/S2, 11x11/S1, 5x5/S2),
// expected windows queued at stimulus time and popped by per-instance monitors.
module tb_fmap_window_buf;

  typedef struct {
    logic [71:0] d;
    int          r;
    int          c;
    int          l;
    int          m;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  exp_t q4[$];
  exp_t q5[$];
  exp_t q11[$];
  int img4 [16];

  // ---- instance A: 4x4, K=2, STRIDE=2
  logic fl4 = 0, wv4 = 0, rdy4 = 1, wrr4, ov4, ol4;
  logic [17:0] wd4 = '0;
  logic [71:0] od4;
  logic [1:0]  orow4, ocol4;
  logic [17:0] omax4;
  // ---- instance B: 5x5, K=2, STRIDE=2
  logic fl5 = 0, wv5 = 0, rdy5 = 1, wrr5, ov5, ol5;
  logic [17:0] wd5 = '0;
  logic [71:0] od5;
  logic [2:0]  orow5, ocol5;
  // ---- instance C: defaults 11x11, K=2, STRIDE=1
  logic fl11 = 0, wv11 = 0, rdy11 = 1, wrr11, ov11, ol11;
  logic [17:0] wd11 = '0;
  logic [71:0] od11;
  logic [3:0]  orow11, ocol11;

  fmap_window_buf #(.DW(18), .ROWS(4), .COLS(4), .K(2), .STRIDE(2)) u_a (
    .clk(clk), .rst_n(rst_n), .flush(fl4), .wr_valid(wv4), .wr_ready(wrr4), .wr_data(wd4),
    .win_valid(ov4), .win_ready(rdy4), .win_data(od4), .win_row(orow4), .win_col(ocol4),
    .win_last(ol4)
`ifdef FMAP_WIN_MAX_EN
    , .win_max(omax4)
`endif
  );
`ifndef FMAP_WIN_MAX_EN
  assign omax4 = '0;
`endif

  fmap_window_buf #(.DW(18), .ROWS(5), .COLS(5), .K(2), .STRIDE(2)) u_b (
    .clk(clk), .rst_n(rst_n), .flush(fl5), .wr_valid(wv5), .wr_ready(wrr5), .wr_data(wd5),
    .win_valid(ov5), .win_ready(rdy5), .win_data(od5), .win_row(orow5), .win_col(ocol5),
    .win_last(ol5)
`ifdef FMAP_WIN_MAX_EN
    , .win_max()
`endif
  );

  fmap_window_buf u_c (
    .clk(clk), .rst_n(rst_n), .flush(fl11), .wr_valid(wv11), .wr_ready(wrr11), .wr_data(wd11),
    .win_valid(ov11), .win_ready(rdy11), .win_data(od11), .win_row(orow11), .win_col(ocol11),
    .win_last(ol11)
`ifdef FMAP_WIN_MAX_EN
    , .win_max()
`endif
  );

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [71:0] pack4(input int a, input int b, input int c, input int d);
    return {18'(d), 18'(c), 18'(b), 18'(a)};
  endfunction

  function automatic int smax4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return int'(18'(m));
  endfunction

  function automatic exp_t mk(input int a, input int b, input int c, input int d,
                              input int r, input int col, input int l);
    exp_t e;
    e.d = pack4(a, b, c, d);
    e.r = r;
    e.c = col;
    e.l = l;
    e.m = smax4(a, b, c, d);
    return e;
  endfunction

  // Window of the 4x4 image at top-left (r,c).
  function automatic exp_t win4(input int r, input int c, input int l);
    return mk(img4[r*4+c], img4[r*4+c+1], img4[(r+1)*4+c], img4[(r+1)*4+c+1], r, c, l);
  endfunction

  task automatic push4_all();
    q4.push_back(win4(0, 0, 0));
    q4.push_back(win4(0, 2, 0));
    q4.push_back(win4(2, 0, 0));
    q4.push_back(win4(2, 2, 1));
  endtask

  task automatic pop_cmp(input int w, input logic [71:0] d, input int r, input int c,
                         input int l, input int m);
    exp_t e;
    int sz;
    sz = (w == 0) ? q4.size() : (w == 1) ? q5.size() : q11.size();
    if (sz == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_window inst%0d: got row %0d col %0d, expected none", w, r, c);
      return;
    end
    if (w == 0)      e = q4.pop_front();
    else if (w == 1) e = q5.pop_front();
    else             e = q11.pop_front();
    chk($sformatf("win_data inst%0d (%0d,%0d)", w, e.r, e.c), d, e.d);
    chki($sformatf("win_row inst%0d", w), r, e.r);
    chki($sformatf("win_col inst%0d", w), c, e.c);
    chki($sformatf("win_last inst%0d (%0d,%0d)", w, e.r, e.c), l, e.l);
`ifdef FMAP_WIN_MAX_EN
    if (w == 0) chki($sformatf("win_max (%0d,%0d)", e.r, e.c), m, e.m);
`endif
  endtask

  // Monitors: a window is consumed on the edge following a negedge with valid && ready.
  always @(negedge clk) begin
    if (rst_n && ov4 && rdy4 && !fl4)
      pop_cmp(0, od4, int'(orow4), int'(ocol4), int'(ol4), int'(omax4));
    if (rst_n && ov5 && rdy5 && !fl5)
      pop_cmp(1, od5, int'(orow5), int'(ocol5), int'(ol5), 0);
    if (rst_n && ov11 && rdy11 && !fl11)
      pop_cmp(2, od11, int'(orow11), int'(ocol11), int'(ol11), 0);
  end

  logic        h4 = 1'b0;
  logic [71:0] hd4;
  int          hr4, hc4, hl4, hm4;
  always @(negedge clk) begin
    if (h4) begin
      chki("hold_valid", int'(ov4), 1);
      chk("hold_data", od4, hd4);
      chki("hold_row", int'(orow4), hr4);
      chki("hold_col", int'(ocol4), hc4);
      chki("hold_last", int'(ol4), hl4);
      chki("hold_max", int'(omax4), hm4);
    end
    h4  = rst_n && ov4 && !rdy4 && !fl4;
    hd4 = od4;
    hr4 = int'(orow4);
    hc4 = int'(ocol4);
    hl4 = int'(ol4);
    hm4 = int'(omax4);
  end

  task automatic wr4_frame(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      wv4 = 1'b1;
      wd4 = 18'(img4[i]);
      @(posedge clk);
      #1;
    end
    wv4 = 1'b0;
  endtask

  task automatic wait_empty(input int w, input int lim);
    int n;
    int sz;
    n = 0;
    sz = (w == 0) ? q4.size() : (w == 1) ? q5.size() : q11.size();
    while (sz != 0 && n < lim) begin
      @(posedge clk);
      n++;
      sz = (w == 0) ? q4.size() : (w == 1) ? q5.size() : q11.size();
    end
    if (sz != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout inst%0d: %0d windows outstanding, expected 0", w, sz);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chki("rst win_valid", int'(ov4), 0);
    chki("rst win_last", int'(ol4), 0);
    chki("rst win_row", int'(orow4), 0);
    chki("rst win_col", int'(ocol4), 0);
    chk("rst win_data", od4, 72'h0);
    chki("rst wr_ready", int'(wrr4), 1);
    chki("rst wr_ready 11x11", int'(wrr11), 1);
`ifdef FMAP_WIN_MAX_EN
    chki("rst win_max", int'(omax4), 0);
`endif

    // 4x4 stride 2, pixels 0..15, hand-computed windows
    for (int i = 0; i < 16; i++) img4[i] = i;
    q4.push_back(mk(0, 1, 4, 5, 0, 0, 0));
    q4.push_back(mk(2, 3, 6, 7, 0, 2, 0));
    q4.push_back(mk(8, 9, 12, 13, 2, 0, 0));
    q4.push_back(mk(10, 11, 14, 15, 2, 2, 1));
    wr4_frame(0, 16);
    @(negedge clk);
    chki("lat valid after last pixel", int'(ov4), 0);
    chki("wr_ready in SCAN", int'(wrr4), 0);
    @(negedge clk);
    chki("lat first window valid", int'(ov4), 1);
    wait_empty(0, 50);
    @(negedge clk);
    chki("wr_ready after drain", int'(wrr4), 1);
    chki("valid after drain", int'(ov4), 0);

    // Signed max patterns: {-3,5,-7,2} and {-1,-2,-3,-4}
    for (int i = 0; i < 16; i++) img4[i] = 0;
    img4[0] = -3; img4[1] = 5;  img4[4] = -7; img4[5] = 2;
    img4[2] = -1; img4[3] = -2; img4[6] = -3; img4[7] = -4;
    img4[10] = 9;
    push4_all();
    wr4_frame(0, 16);
    wait_empty(0, 50);
    @(negedge clk);

    // Backpressure: win_ready toggles every cycle
    for (int i = 0; i < 16; i++) img4[i] = 100 + i;
    push4_all();
    fork
      begin
        for (int i = 0; i < 50; i++) begin
          @(posedge clk);
          #1 rdy4 = ~rdy4;
        end
      end
      wr4_frame(0, 16);
    join
    rdy4 = 1'b1;
    wait_empty(0, 50);
    @(negedge clk);

    // Flush after 7 pixels, with a coinciding write that must be dropped
    for (int i = 0; i < 7; i++) img4[i] = 200 + i;
    wr4_frame(0, 7);
    fl4 = 1'b1; wv4 = 1'b1; wd4 = 18'd999;
    @(posedge clk);
    #1 fl4 = 1'b0; wv4 = 1'b0;
    @(negedge clk);
    chki("flush fill valid", int'(ov4), 0);
    chki("flush fill wr_ready", int'(wrr4), 1);
    for (int i = 0; i < 16; i++) img4[i] = 300 + i;
    push4_all();
    wr4_frame(0, 16);
    wait_empty(0, 50);
    @(negedge clk);

    // Flush during SCAN while the first window is stalled
    rdy4 = 1'b0;
    for (int i = 0; i < 16; i++) img4[i] = 400 + i;
    wr4_frame(0, 16);
    @(negedge clk);
    @(negedge clk);
    chki("scan stalled valid", int'(ov4), 1);
    @(posedge clk);
    #1 fl4 = 1'b1;
    @(posedge clk);
    #1 fl4 = 1'b0;
    @(negedge clk);
    chki("flush scan valid", int'(ov4), 0);
    chki("flush scan wr_ready", int'(wrr4), 1);
    for (int i = 0; i < 16; i++) img4[i] = 500 + i;
    wr4_frame(0, 15);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chki("no scan before refill", int'(ov4), 0);
    end
    push4_all();
    rdy4 = 1'b1;
    wr4_frame(15, 16);
    wait_empty(0, 50);
    @(negedge clk);

    // 5x5 stride 2: trailing row/col 4 skipped; writes during SCAN ignored
    rdy5 = 1'b0;
    q5.push_back(mk(0, 1, 5, 6, 0, 0, 0));
    q5.push_back(mk(2, 3, 7, 8, 0, 2, 0));
    q5.push_back(mk(10, 11, 15, 16, 2, 0, 0));
    q5.push_back(mk(12, 13, 17, 18, 2, 2, 1));
    for (int i = 0; i < 25; i++) begin
      wv5 = 1'b1;
      wd5 = 18'(i);
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < 5; i++) begin
      wv5 = 1'b1;
      wd5 = 18'd777;
      @(negedge clk);
      chki("5x5 wr_ready in SCAN", int'(wrr5), 0);
      @(posedge clk);
      #1;
    end
    wv5 = 1'b0;
    rdy5 = 1'b1;
    wait_empty(1, 50);
    @(negedge clk);
    chki("5x5 wr_ready after drain", int'(wrr5), 1);

    // Defaults 11x11 stride 1, pixel = address: 100 windows back-to-back
    for (int r = 0; r < 10; r++) begin
      for (int c = 0; c < 10; c++) begin
        if (r == 3 && c == 4)
          q11.push_back(mk(37, 38, 48, 49, 3, 4, 0));
        else
          q11.push_back(mk(r*11+c, r*11+c+1, (r+1)*11+c, (r+1)*11+c+1, r, c,
                           (r == 9 && c == 9) ? 1 : 0));
      end
    end
    for (int i = 0; i < 121; i++) begin
      wv11 = 1'b1;
      wd11 = 18'(i);
      @(posedge clk);
      #1;
    end
    wv11 = 1'b0;
    @(negedge clk);
    chki("11x11 lat valid", int'(ov11), 0);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chki($sformatf("11x11 no bubble %0d", i), int'(ov11), 1);
    end
    @(negedge clk);
    chki("11x11 wr_ready after last", int'(wrr11), 1);
    chki("11x11 valid after last", int'(ov11), 0);

    chki("q4 empty at end", q4.size(), 0);
    chki("q5 empty at end", q5.size(), 0);
    chki("q11 empty at end", q11.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fmap_window_buf.md
Name: fmap_window_buf

Overview:
- Parametrised feature-map buffer with window read-out between CNN layers.
- Write side: accepts one ROWS x COLS frame of DW-bit pixels, one pixel per beat, in raster order.
- Read side: once the frame is complete, scans K x K windows at a given STRIDE and presents each one, all pixels in parallel, over a valid/ready handshake.
- Generalises the fixed 11x11, 2x2-window layer-2 RAM: adds sizing parameters, stride, an internal write pointer, scan sequencing and backpressure.

Parameters:
- DW, 18, pixel width in bits.
- ROWS, 11, frame height in pixels.
- COLS, 11, frame width in pixels.
- K, 2, window edge; each window holds K*K pixels.
- STRIDE, 1, window step in both directions.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- flush  in  1  synchronous abort; discards frame and scan, returns to FILL.
- wr_valid  in  1  write pixel valid.
- wr_ready  out  1  buffer accepts a pixel; high only in FILL.
- wr_data  in  DW  pixel, raster order starting at row 0, col 0.
- win_valid  out  1  window output valid.
- win_ready  in  1  consumer accepts window.
- win_data  out  K*K*DW  window pixels; element e=r*K+c at bits [e*DW +: DW]; e=0 is the top-left pixel.
- win_row  out  $clog2(ROWS)  top row of current window.
- win_col  out  $clog2(COLS)  left column of current window.
- win_last  out  1  current window is the final window of the frame.

Behaviour:
- Reset: clk and rst_n are the only clock and reset; reset is synchronous and active-low, sampled on the rising edge of clk.
  - State FILL, write pointer 0, scan counters 0.
  - win_valid=0, win_last=0, win_row=0, win_col=0, win_data=0.
  - wr_ready=1 from the first cycle after reset.
- Storage: register array of ROWS*COLS entries of DW bits. Address = row*COLS+col.
- Window count:
  - NWR = (ROWS-K)/STRIDE+1 and NWC = (COLS-K)/STRIDE+1, using integer floor.
  - Trailing rows or columns that cannot hold a full window are never emitted.
  - Elaboration error if K>ROWS, K>COLS, STRIDE=0 or K=0.
- FILL state:
  - A write occurs when wr_valid && wr_ready; it stores wr_data at the pointer and increments the pointer.
  - On the write to address ROWS*COLS-1: pointer returns to 0, wr_ready drops the next cycle, state moves to SCAN.
- SCAN state:
  - The output register loads when !win_valid || win_ready (load enable).
  - On load: win_data gathers the K*K pixels at base=(wr_idx*STRIDE)*COLS + wc_idx*STRIDE, at offsets r*COLS+c.
  - On the same load, win_row=wr_idx*STRIDE, win_col=wc_idx*STRIDE, win_valid=1, and win_last=1 when wr_idx=NWR-1 and wc_idx=NWC-1.
  - Counters advance in raster order: wc_idx first, wrapping to 0 and incrementing wr_idx.
  - Latency: first window valid exactly 1 cycle after the last pixel is written.
  - With win_ready held high, one window per cycle, no bubbles.
- Backpressure:
  - While win_valid=1 && win_ready=0, win_data, win_row, win_col and win_last stay stable.
  - Counters do not advance while stalled.
- DRAIN state (entered after the last window is loaded):
  - When win_valid && win_ready && win_last: the next cycle win_valid=0, state returns to FILL, wr_ready=1.
  - Frame storage is not cleared on this transition.
- flush:
  - Highest priority in every state; takes effect at the clock edge.
  - Sets state FILL, pointer 0, scan counters 0, win_valid=0, win_last=0.
  - A write or handshake coinciding with flush is discarded.
- rst_n has priority over flush.
- Mid-frame reset or flush: the partial frame is abandoned; the next write lands at address 0.
- wr_valid while wr_ready=0: ignored, with no side effects.

Optional Feature:
- Macro: FMAP_WIN_MAX_EN.
- Defined:
  - Adds output port win_max (DW bits): the signed maximum of the K*K window pixels.
  - Computed combinationally from the gathered pixels and registered on the same load enable as win_data.
  - Same latency and stall stability as win_data; reset value 0.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- ROWS=COLS=4, K=2, STRIDE=2; write pixels 0..15 with win_ready=1 -> exactly 4 windows:
  - {0,1,4,5} at (0,0)
  - {2,3,6,7} at (0,2)
  - {8,9,12,13} at (2,0)
  - {10,11,14,15} at (2,2), with win_last=1.
  - First window valid 1 cycle after pixel 15.
- Defaults (11x11, K=2, STRIDE=1), pixels = address -> 100 windows back-to-back. Window at (3,4) carries {37,38,48,49}. wr_ready returns to 1 one cycle after the final handshake.
- Same 4x4 config; toggle win_ready 0/1 every cycle -> each window is held stable while stalled; no window is duplicated or lost; order unchanged.
- Assert flush after 7 pixels written -> win_valid stays 0, the next pixel lands at address 0. Assert flush during SCAN -> win_valid=0 the next cycle and the scan restarts only after a full refill.
- ROWS=COLS=5, K=2, STRIDE=2 -> NWR=NWC=2, 4 windows; row 4 and column 4 are never emitted. Drive wr_valid during SCAN -> data ignored, frame unchanged.
- FMAP_WIN_MAX_EN defined; window containing {-3,5,-7,2} -> win_max=5. Window containing {-1,-2,-3,-4} -> win_max=-1.
